// File: rtl/decoder_stage_controller.sv
// decoder_stage_controller
// Central sequencer for the union-find processing_unit array. Accepts a
// syndrome round, walks LOAD -> (GROW -> MERGE)* -> PEEL -> RESULT and
// broadcasts the current stage to every PE. The state register itself is
// the global_stage broadcast, so the stage the PEs see is always the
// registered FSM state.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. start_ready is high only in IDLE. result_valid is high for
// the whole RESULT stage. A start request that coincides with the result
// transfer is taken in the following IDLE cycle, because start_ready is
// still low during RESULT.

module decoder_stage_controller #(
    parameter int PU_COUNT       = 64,
    parameter int STAGE_WIDTH    = 3,
    parameter int MAX_ITERATIONS = 32,
    parameter int LOAD_CYCLES    = 2,
    parameter int MERGE_SETTLE   = 4,
    parameter int CYCLE_WIDTH    = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start_valid,
    output logic                                  start_ready,
    input  logic [PU_COUNT-1:0]                   busy,
    input  logic [PU_COUNT-1:0]                   odd,
    output logic [STAGE_WIDTH-1:0]                global_stage,
    output logic                                  result_valid,
    input  logic                                  result_ready,
    output logic [$clog2(MAX_ITERATIONS+1)-1:0]   iteration_count,
    output logic [CYCLE_WIDTH-1:0]                cycle_count,
    output logic                                  timeout
);

    // Stage encodings double as FSM states; 6 and 7 are illegal.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_GROW   = 3'd2,
        ST_MERGE  = 3'd3,
        ST_PEEL   = 3'd4,
        ST_RESULT = 3'd5
    } stage_e;

    localparam int IW = $clog2(MAX_ITERATIONS + 1);
    localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int SW = (MERGE_SETTLE > 1) ? $clog2(MERGE_SETTLE) : 1;

    localparam logic [LW-1:0] LOAD_LAST   = LW'(LOAD_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(MERGE_SETTLE - 1);
    localparam logic [IW-1:0] ITER_MAX    = IW'(MAX_ITERATIONS);

    stage_e                 state_q;
    logic [LW-1:0]          load_cnt_q;
    logic [SW-1:0]          settle_q;
    logic [IW-1:0]          iter_q;
    logic [CYCLE_WIDTH-1:0] cycle_q;
    logic                   timeout_q;
    logic                   result_valid_q;

    logic busy_any;
    logic odd_any;
    logic settled;

    // Array-wide flags and the settle condition shared by MERGE and PEEL:
    // busy low now and low for the previous MERGE_SETTLE-1 cycles.
    assign busy_any = |busy;
    assign odd_any  = |odd;
    assign settled  = !busy_any && (settle_q == SETTLE_LAST);

    assign start_ready     = (state_q == ST_IDLE);
    assign global_stage    = STAGE_WIDTH'(state_q);
    assign result_valid    = result_valid_q;
    assign iteration_count = iter_q;
    assign cycle_count     = cycle_q;
    assign timeout         = timeout_q;

    // Stage sequencer with its counters and registered result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            load_cnt_q     <= '0;
            settle_q       <= '0;
            iter_q         <= '0;
            cycle_q        <= '0;
            timeout_q      <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            // Round latency: counts active stages, saturating at all-ones.
            if (state_q != ST_IDLE && state_q != ST_RESULT && cycle_q != '1) begin
                cycle_q <= cycle_q + CYCLE_WIDTH'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    load_cnt_q     <= '0;
                    settle_q       <= '0;
                    result_valid_q <= 1'b0;
                    if (start_valid) begin
                        state_q   <= ST_LOAD;
                        iter_q    <= '0;
                        cycle_q   <= '0;
                        timeout_q <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (load_cnt_q == LOAD_LAST) begin
                        load_cnt_q <= '0;
                        state_q    <= ST_GROW;
                    end else begin
                        load_cnt_q <= load_cnt_q + LW'(1);
                    end
                end

                ST_GROW: begin
                    iter_q   <= iter_q + IW'(1);
                    settle_q <= '0;
                    state_q  <= ST_MERGE;
                end

                ST_MERGE: begin
                    if (busy_any) begin
                        settle_q <= '0;
                    end else if (settled) begin
                        settle_q <= '0;
                        if (!odd_any) begin
                            state_q <= ST_PEEL;
                        end else if (iter_q < ITER_MAX) begin
                            state_q <= ST_GROW;
                        end else begin
                            state_q        <= ST_RESULT;
                            timeout_q      <= 1'b1;
                            result_valid_q <= 1'b1;
                        end
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end

                ST_PEEL: begin
                    if (busy_any) begin
                        settle_q <= '0;
                    end else if (settled) begin
                        settle_q       <= '0;
                        state_q        <= ST_RESULT;
                        result_valid_q <= 1'b1;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end

                ST_RESULT: begin
                    if (result_ready) begin
                        state_q        <= ST_IDLE;
                        result_valid_q <= 1'b0;
                    end
                end

                default: begin
                    state_q        <= ST_IDLE;
                    load_cnt_q     <= '0;
                    settle_q       <= '0;
                    result_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_stage_controller.sv
// tb_decoder_stage_controller
// Each round is planned up front as a timeline: for every cycle after the
// start accept, the stage the controller should broadcast and the busy/odd
// vectors to drive. The timeline is built from the stage rules (load length,
// one grow cycle, settle windows restarted by busy, odd sampled at exit).
`timescale 1ns/1ps

module tb_decoder_stage_controller;

    localparam int PU_COUNT       = 64;
    localparam int STAGE_WIDTH    = 3;
    localparam int MAX_ITERATIONS = 32;
    localparam int LOAD_CYCLES    = 2;
    localparam int MERGE_SETTLE   = 4;
    localparam int CYCLE_WIDTH    = 32;
    localparam int IW             = $clog2(MAX_ITERATIONS + 1);

    localparam logic [STAGE_WIDTH-1:0] S_IDLE   = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] S_LOAD   = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] S_GROW   = 3'd2;
    localparam logic [STAGE_WIDTH-1:0] S_MERGE  = 3'd3;
    localparam logic [STAGE_WIDTH-1:0] S_PEEL   = 3'd4;
    localparam logic [STAGE_WIDTH-1:0] S_RESULT = 3'd5;

    logic                   clk;
    logic                   reset;
    logic                   start_valid;
    logic                   start_ready;
    logic [PU_COUNT-1:0]    busy;
    logic [PU_COUNT-1:0]    odd;
    logic [STAGE_WIDTH-1:0] global_stage;
    logic                   result_valid;
    logic                   result_ready;
    logic [IW-1:0]          iteration_count;
    logic [CYCLE_WIDTH-1:0] cycle_count;
    logic                   timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Planned round: expected stage per cycle plus the inputs for that cycle.
    logic [STAGE_WIDTH-1:0] exp_q[$];
    logic [PU_COUNT-1:0]    busy_q[$];
    logic [PU_COUNT-1:0]    odd_q[$];
    int                     exp_iter;
    logic                   exp_timeout;

    decoder_stage_controller #(
        .PU_COUNT(PU_COUNT),
        .STAGE_WIDTH(STAGE_WIDTH),
        .MAX_ITERATIONS(MAX_ITERATIONS),
        .LOAD_CYCLES(LOAD_CYCLES),
        .MERGE_SETTLE(MERGE_SETTLE),
        .CYCLE_WIDTH(CYCLE_WIDTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .busy(busy),
        .odd(odd),
        .global_stage(global_stage),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .iteration_count(iteration_count),
        .cycle_count(cycle_count),
        .timeout(timeout)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [PU_COUNT-1:0] rand_vec();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [PU_COUNT-1:0] one_hot();
        logic [PU_COUNT-1:0] v;
        v = '0;
        v[$urandom_range(0, PU_COUNT-1)] = 1'b1;
        return v;
    endfunction

    task automatic push(input logic [STAGE_WIDTH-1:0] st, input logic [PU_COUNT-1:0] b,
                        input logic [PU_COUNT-1:0] o);
        exp_q.push_back(st);
        busy_q.push_back(b);
        odd_q.push_back(o);
    endtask

    // A settle window: optional busy pulse on one PE at cycle 'pulse' of the
    // stage, then MERGE_SETTLE quiet cycles, the last of which is the exit.
    task automatic plan_settle(input logic [STAGE_WIDTH-1:0] st, input int pulse,
                               input bit odd_exit, input bit noisy);
        logic [PU_COUNT-1:0] idle_odd;
        idle_odd = noisy ? rand_vec() : (odd_exit ? '1 : '0);
        for (int c = 1; c <= pulse; c++)
            push(st, (c == pulse) ? one_hot() : '0, noisy ? rand_vec() : idle_odd);
        for (int c = 0; c < MERGE_SETTLE - 1; c++)
            push(st, '0, noisy ? rand_vec() : idle_odd);
        push(st, '0, odd_exit ? (noisy ? one_hot() : '1) : '0);
    endtask

    task automatic plan_round(input int odd_exits, input int first_pulse, input bit noisy);
        int n_grow;
        int pulse;
        exp_q.delete();
        busy_q.delete();
        odd_q.delete();
        for (int i = 0; i < LOAD_CYCLES; i++)
            push(S_LOAD, noisy ? rand_vec() : '0, noisy ? rand_vec() : '0);
        n_grow = (odd_exits >= MAX_ITERATIONS) ? MAX_ITERATIONS : odd_exits + 1;
        for (int j = 0; j < n_grow; j++) begin
            push(S_GROW, noisy ? rand_vec() : '0, noisy ? rand_vec() : '0);
            pulse = noisy ? $urandom_range(0, MERGE_SETTLE) : ((j == 0) ? first_pulse : 0);
            plan_settle(S_MERGE, pulse, j < odd_exits, noisy);
        end
        exp_timeout = (odd_exits >= MAX_ITERATIONS);
        if (!exp_timeout)
            plan_settle(S_PEEL, noisy ? $urandom_range(0, MERGE_SETTLE) : 0, 1'b0, noisy);
        exp_iter = n_grow;
    endtask

    // Driver: accept the round, play the timeline, then hold RESULT for
    // 'hold' cycles before completing the result handshake. abort_at >= 0
    // asserts reset in the middle of that timeline cycle instead.
    task automatic run_round(input int abort_at, input int hold);
        int n;
        int grows;
        n = exp_q.size();
        grows = 0;
        start_valid = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < n; t++) begin
            busy = busy_q[t];
            odd  = odd_q[t];
            start_valid  = 1'($urandom_range(0, 1));
            result_ready = 1'($urandom_range(0, 1));
            if (exp_q[t] == S_GROW) grows++;
            if (t == abort_at) begin
                #2;
                check("pre_reset_iter", iteration_count, grows);
                check("pre_reset_cycles", cycle_count, t);
                reset = 1'b0;
                #1;
                check("async_reset_stage", global_stage, S_IDLE);
                check("async_reset_rvalid", result_valid, 0);
                check("async_reset_iter", iteration_count, 0);
                check("async_reset_cycles", cycle_count, 0);
                check("async_reset_timeout", timeout, 0);
                check("async_reset_sready", start_ready, 1);
                @(posedge clk); #1;
                check("reset_hold_stage", global_stage, S_IDLE);
                @(negedge clk);
                busy = '0;
                odd = '0;
                start_valid = 1'b0;
                result_ready = 1'b0;
                reset = 1'b1;
                return;
            end
            @(negedge clk);
            check("stage", global_stage, exp_q[t]);
            check("cycles_running", cycle_count, t);
            check("rvalid_low", result_valid, 0);
            check("sready_low", start_ready, 0);
            @(posedge clk); #1;
        end
        busy = '0;
        odd = '0;
        start_valid = 1'b1;
        result_ready = 1'b0;
        @(negedge clk);
        check("result_stage", global_stage, S_RESULT);
        check("result_valid", result_valid, 1);
        check("result_iter", iteration_count, exp_iter);
        check("result_cycles", cycle_count, n);
        check("result_timeout", timeout, exp_timeout);
        check("result_sready", start_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_stage", global_stage, S_RESULT);
            check("hold_valid", result_valid, 1);
            check("hold_iter", iteration_count, exp_iter);
            check("hold_cycles", cycle_count, n);
            check("hold_timeout", timeout, exp_timeout);
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        start_valid = 1'b0;
        @(negedge clk);
        check("done_stage", global_stage, S_IDLE);
        check("done_rvalid", result_valid, 0);
        check("done_sready", start_ready, 1);
        check("done_iter", iteration_count, exp_iter);
        check("done_cycles", cycle_count, n);
        check("done_timeout", timeout, exp_timeout);
    endtask

    // Scenario sequence and final report
    initial begin
        reset = 1'b0;
        start_valid = 1'b0;
        result_ready = 1'b0;
        busy = '0;
        odd = '0;
        #3;
        check("rst_stage", global_stage, S_IDLE);
        check("rst_rvalid", result_valid, 0);
        check("rst_sready", start_ready, 1);
        check("rst_iter", iteration_count, 0);
        check("rst_cycles", cycle_count, 0);
        check("rst_timeout", timeout, 0);
        start_valid = 1'b1;
        @(posedge clk); #1;
        check("rst_ignores_start", global_stage, S_IDLE);
        start_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        plan_round(0, 0, 1'b0);                 run_round(-1, 5);
        plan_round(2, 0, 1'b0);                 run_round(-1, 1);
        plan_round(0, 3, 1'b0);                 run_round(-1, 0);
        plan_round(MAX_ITERATIONS, 0, 1'b0);    run_round(-1, 2);
        plan_round(2, 0, 1'b0);
        run_round(LOAD_CYCLES + 1 + MERGE_SETTLE + 1 + 1, 0);
        plan_round(0, 0, 1'b0);                 run_round(-1, 0);
        for (int r = 0; r < 12; r++) begin
            plan_round($urandom_range(0, 4), 0, 1'b1);
            run_round(-1, $urandom_range(0, 5));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
